// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bcd_pkg
//  Description : Shared state encoding, key codes and helpers for the keypad
//                BCD entry controller and its converter.
//  Contents    : ST_* state codes, state_t enum, KEY_* codes, is_digit()
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

    // Controller state codes, 3 bits wide
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ENTRY = 3'd1;
    localparam logic [2:0] ST_CONV  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ENTRY = ST_ENTRY,
        S_CONV  = ST_CONV,
        S_CHECK = ST_CHECK,
        S_HOLD  = ST_HOLD,
        S_ERR   = ST_ERR
    } state_t;

    // Keypad decoder codes; 0-9 are digits, C-F carry no meaning here
    localparam logic [3:0] KEY_MINUS = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd3_to_mag.sv
`default_nettype none
// ============================================================================
//  Module      : bcd3_to_mag
//  Description : Combinational 3-digit BCD to 10-bit binary magnitude,
//                hund*100 + tens*10 + ones, built from shifts and adds.
//  Ports       : hund, tens, ones  in  4  BCD digits (0-9 each)
//                mag               out 10 binary magnitude, 0..999
//  Revision    : 1.0  initial release
// ============================================================================
module bcd3_to_mag (
    input  logic [3:0] hund,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [9:0] mag
);

    logic [9:0] w_hund;
    logic [9:0] w_tens;
    logic [9:0] w_ones;

    assign w_hund = {6'b0, hund};
    assign w_tens = {6'b0, tens};
    assign w_ones = {6'b0, ones};

    // x*100 = 64x + 32x + 4x ; x*10 = 8x + 2x. Max 999 fits in 10 bits.
    assign mag = (w_hund << 6) + (w_hund << 5) + (w_hund << 2)
               + (w_tens << 3) + (w_tens << 1)
               + w_ones;

endmodule : bcd3_to_mag
`default_nettype wire

// File: rtl/bcd_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_entry_ctrl
//  Description : Sequences keypad entry of a signed 3-digit BCD number and
//                converts it to an N-bit sign-magnitude result with range
//                check. IDLE -> ENTRY -> CONV -> CHECK -> HOLD | ERR.
//  Ports       : clk           in   1  clock, rising edge
//                reset_n       in   1  synchronous active-low reset
//                clear         in   1  synchronous clear of entry/result
//                key_valid     in   1  key strobe
//                key_code      in   4  0-9 digit, A minus, B enter
//                bcd_word      out 16  {sign,3'b0,hund,tens,ones}
//                digit_count   out  2  digits accepted so far
//                busy          out  1  high in CONV and CHECK
//                result        out  N  held sign-magnitude result
//                result_valid  out  1  one-cycle pulse on result update
//                error         out  1  last conversion out of range
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_entry_ctrl
    import bcd_pkg::*;
#(
    parameter int N      = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          key_valid,
    input  logic [3:0]    key_code,
    output logic [15:0]   bcd_word,
    output logic [1:0]    digit_count,
    output logic          busy,
    output logic [N-1:0]  result,
    output logic          result_valid,
    output logic          error
);

    localparam int unsigned c_MAXMAG    = (2 ** (N - 1)) - 1;
    localparam logic [1:0]  c_MAX_COUNT = 2'(DIGITS);

    state_t       r_state,        w_state_nxt;
    logic [15:0]  r_bcd_word,     w_bcd_word_nxt;
    logic [1:0]   r_digit_count,  w_digit_count_nxt;
    logic [9:0]   r_mag,          w_mag_nxt;
    logic [N-1:0] r_result,       w_result_nxt;
    logic         r_result_valid, w_result_valid_nxt;
    logic         r_error,        w_error_nxt;

    logic [9:0]   w_mag;
    logic         w_is_digit;

    bcd3_to_mag u_bcd3_to_mag (
        .hund (r_bcd_word[11:8]),
        .tens (r_bcd_word[7:4]),
        .ones (r_bcd_word[3:0]),
        .mag  (w_mag)
    );

    assign w_is_digit = is_digit(key_code);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_bcd_word     <= 16'h0000;
            r_digit_count  <= 2'd0;
            r_mag          <= 10'd0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_bcd_word     <= w_bcd_word_nxt;
            r_digit_count  <= w_digit_count_nxt;
            r_mag          <= w_mag_nxt;
            r_result       <= w_result_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_error        <= w_error_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt        = r_state;
        w_bcd_word_nxt     = r_bcd_word;
        w_digit_count_nxt  = r_digit_count;
        w_mag_nxt          = r_mag;
        w_result_nxt       = r_result;
        w_result_valid_nxt = 1'b0;
        w_error_nxt        = r_error;

        if (clear) begin
            // Clear wins over any key arriving in the same cycle
            w_state_nxt       = S_IDLE;
            w_bcd_word_nxt    = 16'h0000;
            w_digit_count_nxt = 2'd0;
            w_result_nxt      = '0;
            w_error_nxt       = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_HOLD, S_ERR: begin
                    // A new key starts a fresh entry; the previous result
                    // stays on display until the next conversion.
                    if (key_valid) begin
                        if (w_is_digit) begin
                            w_bcd_word_nxt    = {12'h000, key_code};
                            w_digit_count_nxt = 2'd1;
                            w_error_nxt       = 1'b0;
                            w_state_nxt       = S_ENTRY;
                        end else if (key_code == KEY_MINUS) begin
                            w_bcd_word_nxt    = 16'h8000;
                            w_digit_count_nxt = 2'd0;
                            w_error_nxt       = 1'b0;
                            w_state_nxt       = S_ENTRY;
                        end
                    end
                end

                S_ENTRY: begin
                    if (key_valid) begin
                        if (w_is_digit) begin
                            if (r_digit_count < c_MAX_COUNT) begin
                                w_bcd_word_nxt[11:0] = {r_bcd_word[7:0], key_code};
                                w_digit_count_nxt    = r_digit_count + 2'd1;
                            end
                        end else if (key_code == KEY_MINUS) begin
                            // Sign can only be changed before the first digit
                            if (r_digit_count == 2'd0) begin
                                w_bcd_word_nxt[15] = ~r_bcd_word[15];
                            end
                        end else if (key_code == KEY_ENTER) begin
                            w_state_nxt = S_CONV;
                        end
                    end
                end

                S_CONV: begin
                    w_mag_nxt   = w_mag;
                    w_state_nxt = S_CHECK;
                end

                S_CHECK: begin
                    w_result_valid_nxt = 1'b1;
                    if (32'(r_mag) > c_MAXMAG) begin
                        w_result_nxt = '0;
                        w_error_nxt  = 1'b1;
                        w_state_nxt  = S_ERR;
                    end else begin
                        // Sign is suppressed for a zero magnitude so -0 reads as 0
                        w_result_nxt = {r_bcd_word[15] & (r_mag != 10'd0), r_mag[N-2:0]};
                        w_error_nxt  = 1'b0;
                        w_state_nxt  = S_HOLD;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign bcd_word     = r_bcd_word;
    assign digit_count  = r_digit_count;
    assign busy         = (r_state == S_CONV) || (r_state == S_CHECK);
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign error        = r_error;

endmodule : bcd_entry_ctrl
`default_nettype wire
